byte_sram_adapter: RTL

//  Memory-side endpoint of the byte bus: takes the single request stream from the byte mux
//  (enable/isWrite/mask/addr/wdata, hold-based flow control) and drives a synchronous SRAM macro

---
 rtl/byte_pkg.sv | 19 +
 rtl/byte_sram_adapter_if.sv | 34 +++
 rtl/byte_sram_adapter.sv | 87 ++++++++
 3 files changed

// File: rtl/byte_pkg.sv
// Shared definitions for the byte bus SRAM endpoint: FSM states, latency limit
// and the byte-offset width helper.
package byte_pkg;

  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/byte_sram_adapter_if.sv
// Byte bus request/response channel and synchronous SRAM macro port.
interface byte_bus_if #(
  parameter int DATA_BYTE = 4,
  parameter int ADDR_SIZE = 32
);
  logic                     enable;
  logic                     is_write;
  logic [DATA_BYTE-1:0]     write_mask;
  logic [ADDR_SIZE-1:0]     addr;
  logic [DATA_BYTE*8-1:0]   write_data;
  logic [DATA_BYTE*8-1:0]   read_data;
  logic                     hold;
  logic                     err;

  modport master (output enable, is_write, write_mask, addr, write_data,
                  input  read_data, hold, err);
  modport slave  (input  enable, is_write, write_mask, addr, write_data,
                  output read_data, hold, err);
endinterface

interface sram_if #(
  parameter int DATA_BYTE = 4,
  parameter int SRAM_AW   = 10
);
  logic                     ce;
  logic                     we;
  logic [DATA_BYTE-1:0]     be;
  logic [SRAM_AW-1:0]       addr;
  logic [DATA_BYTE*8-1:0]   wdata;
  logic [DATA_BYTE*8-1:0]   rdata;

  modport master (output ce, we, be, addr, wdata, input rdata);
  modport slave  (input  ce, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/byte_sram_adapter.sv
// Byte bus endpoint driving a fixed-latency synchronous SRAM. Writes complete in
// the issue cycle; reads stall the requester for RD_LATENCY cycles.
module byte_sram_adapter
  import byte_pkg::*;
#(
  parameter int                   DATA_BYTE  = 4,
  parameter int                   ADDR_SIZE  = 32,
  parameter int                   SRAM_AW    = 10,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0,
  parameter int                   RD_LATENCY = 1,
  parameter bit                   HOLDENABLE = 1'b1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  byte_bus_if.slave bus,
  sram_if.master    sram
);

  localparam int                   OFF_W     = clog2(DATA_BYTE);
  localparam logic [ADDR_SIZE-1:0] WIN_BYTES = ADDR_SIZE'(DATA_BYTE) << SRAM_AW;
  localparam logic [1:0]           CNT_INIT  = 2'(RD_LATENCY - 1);
  localparam logic [0:0]           S_IDLE    = IDLE;
  localparam logic [0:0]           S_WAIT    = WAIT;

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("byte_sram_adapter: RD_LATENCY out of range 1..%0d", MAX_RD_LATENCY);
  end
  if ((1 << OFF_W) != DATA_BYTE) begin : g_bad_data_byte
    $error("byte_sram_adapter: DATA_BYTE must be a power of two");
  end
  if ((BASE_ADDR & (WIN_BYTES - 1'b1)) != '0) begin : g_bad_base
    $error("byte_sram_adapter: BASE_ADDR not aligned to the SRAM window");
  end

  logic [0:0]           state_q;
  logic [1:0]           cnt_q;
  logic [ADDR_SIZE-1:0] offs;
  logic                 in_win;
  logic                 idle_req;
  logic                 rd_issue;
  logic                 wr_issue;
  logic                 rd_done;
  logic                 busy;

  // Every strobe is qualified with rst_ni so outputs read 0 for the whole reset window.
  always_comb begin
    offs     = bus.addr - BASE_ADDR;
    in_win   = offs < WIN_BYTES;
    idle_req = rst_ni && (state_q == S_IDLE) && bus.enable;
    rd_issue = idle_req && in_win && !bus.is_write;
    wr_issue = idle_req && in_win && bus.is_write;
    rd_done  = rst_ni && (state_q == S_WAIT) && (cnt_q == 2'd0);
    busy     = rd_issue || (rst_ni && (state_q == S_WAIT) && (cnt_q != 2'd0));
  end

  assign sram.addr  = SRAM_AW'(offs >> OFF_W);
  assign sram.ce    = rd_issue || wr_issue;
  assign sram.we    = wr_issue;
  assign sram.be    = wr_issue ? bus.write_mask : '0;
  assign sram.wdata = bus.write_data;

  assign bus.hold      = HOLDENABLE ? (busy && bus.enable) : busy;
  assign bus.err       = idle_req && !in_win;
  // An abandoned read (enable dropped in WAIT) still drains but never shows its data.
  assign bus.read_data = (rd_done && bus.enable) ? sram.rdata : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_issue) begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        default: begin
          if (cnt_q == 2'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 2'd1;
        end
      endcase
    end
  end

endmodule
